// File: rtl/shot_pkg.sv
// Shared types and defaults for the shot evaluator (see SHOT_DEBOUNCE_EN in shot_evaluator).
package shot_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    READY    = 2'd1,
    COOLDOWN = 2'd2
  } shot_state_t;

  localparam int HIT_COUNT_MAX           = 255;
  localparam int DEFAULT_AMMO            = 3;
  localparam int DEFAULT_COOLDOWN_CYCLES = 3_250_000;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 65_000;

  // Score increment that holds at the ceiling instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'(HIT_COUNT_MAX)) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/click_debouncer.sv
// Mouse-button debouncer: level follows raw only after raw holds a new value
// for DEBOUNCE_CYCLES consecutive clk cycles.
module click_debouncer #(
  parameter int DEBOUNCE_CYCLES = 65_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  // Count consecutive cycles of disagreement; flip the level once the run is long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
      level <= 1'b0;
    end else if (raw == level) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= {CNT_W{1'b0}};
      level <= raw;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/shot_evaluator.sv
// Turns trigger pulls into one-cycle hit/miss events with ammo, cooldown and score.
// Optional build macro SHOT_DEBOUNCE_EN inserts click_debouncer on mouse_left.
module shot_evaluator
  import shot_pkg::*;
#(
  parameter int AMMO            = DEFAULT_AMMO,
  parameter int COOLDOWN_CYCLES = DEFAULT_COOLDOWN_CYCLES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mouse_left,
  input  logic                       mouse_on_target,
  input  logic                       target_active,
  input  logic                       round_start,
  output logic                       hit,
  output logic                       miss,
  output logic [$clog2(AMMO+1)-1:0]  ammo,
  output logic [7:0]                 hit_count,
  output logic                       busy
);

  localparam int AMMO_W = $clog2(AMMO + 1);
  localparam int CNT_W  = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

  logic btn_s;
  logic btn_q_r;
  logic fire_s;

`ifdef SHOT_DEBOUNCE_EN
  click_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_click_debouncer (
    .clk   (clk),
    .rst   (rst),
    .raw   (mouse_left),
    .level (btn_s)
  );
`else
  assign btn_s = mouse_left;
`endif

  assign fire_s = btn_s & ~btn_q_r;

  shot_state_t       state_r, state_nx_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
  logic [AMMO_W-1:0] ammo_nx_s;
  logic [7:0]        hit_count_nx_s;
  logic              hit_nx_s, miss_nx_s, busy_nx_s;

  // Next-state, ammo, score and pulse decode; round_start overrides everything.
  always_comb begin
    state_nx_s     = state_r;
    cnt_nx_s       = cnt_r;
    ammo_nx_s      = ammo;
    hit_count_nx_s = hit_count;
    hit_nx_s       = 1'b0;
    miss_nx_s      = 1'b0;
    if (round_start) begin
      state_nx_s = READY;
      ammo_nx_s  = AMMO_W'(AMMO);
      cnt_nx_s   = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        EMPTY: begin
          state_nx_s = EMPTY;
        end
        READY: begin
          if (fire_s && (ammo != {AMMO_W{1'b0}})) begin
            if (target_active && mouse_on_target) begin
              hit_nx_s       = 1'b1;
              hit_count_nx_s = sat_inc8(hit_count);
            end else begin
              miss_nx_s = 1'b1;
            end
            ammo_nx_s = ammo - AMMO_W'(1);
            if (ammo == AMMO_W'(1)) begin
              state_nx_s = EMPTY;
            end else begin
              state_nx_s = COOLDOWN;
              cnt_nx_s   = CNT_LOAD;
            end
          end else begin
            state_nx_s = READY;
          end
        end
        COOLDOWN: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_nx_s = READY;
          end else begin
            cnt_nx_s = cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_nx_s = EMPTY;
          cnt_nx_s   = {CNT_W{1'b0}};
        end
      endcase
    end
    busy_nx_s = (state_nx_s == COOLDOWN);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= EMPTY;
      cnt_r     <= {CNT_W{1'b0}};
      btn_q_r   <= 1'b0;
      ammo      <= {AMMO_W{1'b0}};
      hit_count <= 8'd0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      btn_q_r   <= btn_s;
      ammo      <= ammo_nx_s;
      hit_count <= hit_count_nx_s;
      hit       <= hit_nx_s;
      miss      <= miss_nx_s;
      busy      <= busy_nx_s;
    end
  end

endmodule

// File: tb/tb_shot_evaluator.sv
// Directed bench for shot_evaluator with a timestamp-based reference model.
// Build with SHOT_DEBOUNCE_EN defined to exercise the debounced variant.
module tb_shot_evaluator;

  localparam int C = 4;
  localparam int A = 3;
  localparam int D = 3;
`ifdef SHOT_DEBOUNCE_EN
  localparam int DLAT = D;
`else
  localparam int DLAT = 0;
`endif
  localparam int HOLD = DLAT + 1;
  localparam int GAP  = DLAT + C + 3;

  logic       clk = 1'b0;
  logic       rst, mouse_left, mouse_on_target, target_active, round_start;
  logic       hit, miss, busy;
  logic [1:0] ammo;
  logic [7:0] hit_count;

  shot_evaluator #(
    .AMMO            (A),
    .COOLDOWN_CYCLES (C),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mouse_left      (mouse_left),
    .mouse_on_target (mouse_on_target),
    .target_active   (target_active),
    .round_start     (round_start),
    .hit             (hit),
    .miss            (miss),
    .ammo            (ammo),
    .hit_count       (hit_count),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic click();
    mouse_left = 1'b1;
    tick(HOLD);
    mouse_left = 1'b0;
    tick(GAP);
  endtask

  // Reference model: a shot is accepted when ammo remains and the current
  // cycle has reached the earliest-accept timestamp.
  int   m_ammo = 0, m_hc = 0, m_accept = 0, m_cyc = 0, m_run = 0;
  logic m_btn_prev = 1'b0, m_deb = 1'b0, m_last_raw = 1'b0, m_valid = 1'b0;
  logic e_hit = 1'b0, e_miss = 1'b0, e_busy = 1'b0;

  always @(posedge clk) begin : model
    logic b, f;
`ifdef SHOT_DEBOUNCE_EN
    b = m_deb;
`else
    b = mouse_left;
`endif
    f = b & ~m_btn_prev;
    m_btn_prev = b;
    m_run = (mouse_left == m_last_raw) ? m_run + 1 : 1;
    m_last_raw = mouse_left;
    if (m_run >= D) m_deb = mouse_left;
    e_hit  = 1'b0;
    e_miss = 1'b0;
    if (rst) begin
      m_valid = 1'b1; m_ammo = 0; m_hc = 0; m_accept = 0;
      m_btn_prev = 1'b0; m_deb = 1'b0; m_last_raw = 1'b0; m_run = 0;
    end else if (round_start) begin
      m_ammo = A;
      m_accept = m_cyc + 1;
    end else if (f && m_ammo > 0 && m_cyc >= m_accept) begin
      if (target_active && mouse_on_target) begin
        e_hit = 1'b1;
        if (m_hc < 255) m_hc++;
      end else begin
        e_miss = 1'b1;
      end
      m_ammo--;
      m_accept = m_cyc + 1 + C;
    end
    e_busy = (m_ammo > 0) && (m_cyc + 1 < m_accept);
    m_cyc++;
  end

  int hits_seen = 0;
  int miss_seen = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_hit", hit, int'(e_hit));
      check("model_miss", miss, int'(e_miss));
      check("model_ammo", ammo, m_ammo);
      check("model_hit_count", hit_count, m_hc);
      check("model_busy", busy, int'(e_busy));
      hits_seen += int'(hit);
      miss_seen += int'(miss);
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    rst = 1'b1; mouse_left = 1'b0; mouse_on_target = 1'b0;
    target_active = 1'b0; round_start = 1'b0;
    tick(3);
    check("reset_ammo", ammo, 0);
    check("reset_hit_count", hit_count, 0);
    check("reset_busy", busy, 0);
    check("reset_pulses", {hit, miss}, 0);
    rst = 1'b0;
    tick(2);

    round_start = 1'b1;
    tick(1);
    round_start = 1'b0;
    check("rs_ammo", ammo, 3);
    check("rs_busy", busy, 0);
    check("rs_hit_count", hit_count, 0);
    tick(DLAT + 2);

    mouse_on_target = 1'b1; target_active = 1'b1; mouse_left = 1'b1;
    tick(1 + DLAT);
    check("shot1_hit", hit, 1);
    check("shot1_ammo", ammo, 2);
    check("shot1_hit_count", hit_count, 1);
    check("shot1_busy", busy, 1);
`ifndef SHOT_DEBOUNCE_EN
    mouse_left = 1'b0;
    tick(1);
    check("shot1_pulse_width", hit, 0);
    mouse_left = 1'b1;
    tick(1);
    check("cooldown_click_ignored", {hit, miss}, 0);
    mouse_left = 1'b0; mouse_on_target = 1'b0;
    tick(1);
    check("busy_last_cycle", busy, 1);
    tick(1);
    check("ready_after_cooldown", busy, 0);
    mouse_left = 1'b1;
    tick(1);
    check("shot2_miss", miss, 1);
    check("shot2_no_hit", hit, 0);
    check("shot2_ammo", ammo, 1);
    mouse_left = 1'b0;
    tick(GAP);
`else
    mouse_left = 1'b0;
    tick(GAP);
    mouse_on_target = 1'b0;
    click();
    check("shot2_miss_count", miss_seen, 1);
    check("shot2_ammo", ammo, 1);
`endif

    mouse_on_target = 1'b1;
    click();
    check("empty_ammo", ammo, 0);
    check("empty_busy", busy, 0);
    check("empty_hits", hits_seen, 2);
    click();
    check("empty_click_no_pulse", hits_seen + miss_seen, 3);

    mouse_left = 1'b1;
    tick(DLAT);
    round_start = 1'b1;
    tick(1);
    round_start = 1'b0;
    check("rs_coinc_empty_ammo", ammo, 3);
    check("rs_coinc_empty_pulse", {hit, miss}, 0);
    mouse_left = 1'b0;
    tick(GAP);

    mouse_left = 1'b1;
    tick(DLAT);
    round_start = 1'b1;
    tick(1);
    round_start = 1'b0;
    check("rs_coinc_ready_ammo", ammo, 3);
    check("rs_coinc_ready_pulse", {hit, miss}, 0);
    check("rs_coinc_ready_busy", busy, 0);
    mouse_left = 1'b0;
    tick(GAP);

    mouse_left = 1'b1;
    tick(20);
    mouse_left = 1'b0;
    tick(GAP);
    check("hold_single_shot", hits_seen + miss_seen, 4);
    check("hold_ammo", ammo, 2);

`ifdef SHOT_DEBOUNCE_EN
    mouse_left = 1'b1;
    tick(2);
    mouse_left = 1'b0;
    tick(GAP);
    check("glitch_no_shot", hits_seen + miss_seen, 4);
    mouse_left = 1'b1;
    tick(3);
    mouse_left = 1'b0;
    tick(1);
    check("debounce_latency_hit", hit, 1);
    tick(GAP);
    check("debounce_ammo", ammo, 1);
`endif

    for (int r = 0; r < 86; r++) begin
      round_start = 1'b1;
      tick(1);
      round_start = 1'b0;
      repeat (3) click();
    end
    check("hit_count_saturated", hit_count, 255);
    check("sat_ammo", ammo, 0);

    round_start = 1'b1;
    tick(1);
    round_start = 1'b0;
    mouse_left = 1'b1;
    tick(HOLD);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1; mouse_left = 1'b0;
    tick(1);
    check("rst_mid_cooldown_busy", busy, 0);
    check("rst_mid_cooldown_ammo", ammo, 0);
    check("rst_mid_cooldown_hit_count", hit_count, 0);
    rst = 1'b0;
    tick(GAP);
    click();
    check("post_rst_empty_click", hit_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shot_evaluator.md
# shot_evaluator

Consumes the registered on-target flag from the mouse hit detector and the left mouse button, and turns each trigger pull into a one-cycle `hit` or `miss` event for the game logic. It tracks remaining ammunition per round and enforces a post-shot cooldown. A shared `hit_count` score register feeds the on-screen overlay. Sits between the mouse/hit-detection front end and the game-state controller.

## Interface
- `AMMO`, 3: shots available after each `round_start`.
- `COOLDOWN_CYCLES`, 3_250_000: dead time after a shot, in `clk` cycles (50 ms at 65 MHz); must be ≥ 1.
- `DEBOUNCE_CYCLES`, 65_000: stability window for `mouse_left`; used only with `SHOT_DEBOUNCE_EN`.
- `clk` in 1: system pixel clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `mouse_left` in 1: left-button level from the mouse controller, already in the `clk` domain.
- `mouse_on_target` in 1: registered on-target flag from the hit detector.
- `target_active` in 1: target currently flying and shootable.
- `round_start` in 1: one-cycle pulse that reloads ammo.
- `hit` out 1: one-cycle pulse for a shot on an active target.
- `miss` out 1: one-cycle pulse for any other shot.
- `ammo` out `$clog2(AMMO+1)`: remaining shots.
- `hit_count` out 8: total hits, saturating at 255.
- `busy` out 1: high in COOLDOWN.

## Operation
- Click edge: `fire = btn & ~btn_q`.
  - `btn` is `mouse_left`, or its debounced version when `SHOT_DEBOUNCE_EN` is defined.
  - `btn_q` is `btn` registered.
- States:
  - EMPTY: reset state. Ignores clicks.
  - READY: accepts a shot.
  - COOLDOWN: counts down. Ignores clicks.
- READY with `fire`:
  - `hit` if `target_active & mouse_on_target`, otherwise `miss`.
  - `ammo` decrements.
  - If the new `ammo` is 0, go to EMPTY.
  - Otherwise go to COOLDOWN with the counter loaded to `COOLDOWN_CYCLES-1`.
- COOLDOWN: counter decrements each cycle. At counter 0, go to READY in the following cycle.
- `round_start` in any state: `ammo <= AMMO`, state becomes READY, cooldown counter cleared.
  - Has priority over a coincident `fire`. That click is discarded: no `hit`, no `miss`, no decrement.
- `hit_count` increments on each `hit`. It saturates at 255 and is cleared only by `rst`.
- `hit` and `miss` are mutually exclusive. At most one shot is evaluated per edge; holding the button does not auto-fire.
- No arithmetic wrap: `ammo` never goes below 0, and `hit_count` never exceeds 255.

## Timing
- Reset values: state EMPTY, `ammo` 0, `hit_count` 0, `hit`/`miss`/`busy` 0, `btn_q` 0, all counters 0.
- `rst` mid-cooldown or mid-debounce aborts all activity next edge; no pending pulse survives it.
- Shot latency: a `fire` in cycle N gives `hit`/`miss` high in cycle N+1 only. `ammo`, `hit_count` and the state also update in N+1.
- `mouse_on_target` and `target_active` are sampled in cycle N, the same cycle as `fire`.
- Cooldown: the next shot is accepted no earlier than N+1+`COOLDOWN_CYCLES`. `busy` is high for exactly `COOLDOWN_CYCLES` cycles.
- With `SHOT_DEBOUNCE_EN`, click-to-`fire` latency increases by `DEBOUNCE_CYCLES`.

## Configuration
- Macro: `SHOT_DEBOUNCE_EN`.
- Defined: `btn` changes value only after `mouse_left` has held a new level for `DEBOUNCE_CYCLES` consecutive cycles. A glitch shorter than that produces no shot.
- Undefined: `btn = mouse_left` directly; the debounce counter is not built.

## Structure
- Package `shot_pkg`:
  - `shot_state_t` enum {EMPTY, READY, COOLDOWN}.
  - `HIT_COUNT_MAX` = 255.
  - Default `AMMO` and `COOLDOWN_CYCLES` constants.
- Sub-module `click_debouncer`: holds the debounce counter and registered level; instantiated only under `SHOT_DEBOUNCE_EN`.
- Edge detect, FSM, ammo counter and score counter live in `shot_evaluator`.

## Test plan
All scenarios use `COOLDOWN_CYCLES=4` and `AMMO=3`; the debounce scenario also uses `DEBOUNCE_CYCLES=3`.
- Reset, then `round_start` -> `ammo`=3, state READY, `hit`/`miss`/`hit_count` = 0.
- Click with `mouse_on_target`=1 and `target_active`=1 -> `hit` is one cycle high at N+1, `ammo`=2, `hit_count`=1, `busy` high for 4 cycles.
- Click during cooldown, then a second click on target off (`mouse_on_target`=0) at N+5 -> first click ignored, second click gives `miss` with `ammo`=1.
- Three valid shots -> `ammo`=0, state EMPTY. A fourth click gives no pulse. `round_start` coincident with a click -> `ammo`=3 and no pulse.
- Hold `mouse_left` high for 20 cycles -> exactly one shot pulse.
- `SHOT_DEBOUNCE_EN` with a 2-cycle glitch -> no shot. A 3-cycle stable press -> shot 3 cycles later than without the macro.
- 256 hits across repeated rounds -> `hit_count` saturates at 255.
